user_event_gen: RTL and testbench
=================================

Name: user_event_gen

Overview:
- Producer end of the user-event interface consumed by the game FSM: turns five raw button/key lines into 3-bit EV_* codes.
- Codes are held in a show-ahead FIFO and popped by the consumer's read request.
- Per key: synchronisation, debounce, press-edge detection and auto-repeat.
- Sits between board button pins and main game logic.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive stable synced cycles required to accept a key level change (>=1)
REPEAT_DELAY, 12500000, cycles a key is held after its accepted press before the first auto-repeat
REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeats while held
FIFO_DEPTH, 8, event FIFO entries; power of two, >=2

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous active-high reset
key_left_i  in  1  raw asynchronous button, 1 = pressed
key_right_i  in  1  raw button
key_down_i  in  1  raw button
key_rotate_i  in  1  raw button
key_new_game_i  in  1  raw button
user_event_o  out  3  EV_* code at FIFO head, valid while user_event_ready_o=1
user_event_ready_o  out  1  FIFO non-empty
user_event_rd_req_i  in  1  pop head; honoured only when user_event_ready_o=1
overflow_o  out  1  sticky: an event was discarded (optional feature only, else tied 0)

Behaviour:
- Reset: all sync flops, debounced levels, counters, pending flags and FIFO pointers cleared.
  - user_event_o=0, user_event_ready_o=0, overflow_o=0.
  - A key held through reset is seen as released at reset and produces one press after debounce.
- Sync: two flops per key; raw change visible at sync output after 2 cycles.
- Debounce, per key:
  - Counter counts while synced level != debounced level; resets to 0 whenever they match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the synced level and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored.
- Press detect: a 0->1 change of the debounced level sets that key's pending flag on the same edge.
- Auto-repeat, LEFT/RIGHT/DOWN only:
  - Repeat counter starts at accepted press.
  - First repeat when the counter reaches REPEAT_DELAY, then every REPEAT_PERIOD while the debounced level stays 1.
  - Release clears the counter.
  - ROTATE and NEW_GAME never repeat.
  - A repeat hitting an already-set pending flag coalesces (no extra event).
- Arbiter:
  - At most one FIFO push per cycle.
  - Among set pending flags, fixed priority NEW_GAME > ROTATE > DOWN > LEFT > RIGHT.
  - The winner's EV_* code is written and its flag cleared in the same cycle.
  - Codes: EV_LEFT, EV_RIGHT, EV_DOWN, EV_ROTATE, EV_NEW_GAME from the shared defines header.
- FIFO:
  - Show-ahead. user_event_ready_o and user_event_o are registered from FIFO state, so a push is visible the cycle after the write.
  - Push is allowed when not full, or when full and a valid pop occurs in the same cycle.
  - When the FIFO is full and no pop occurs, pending flags stay set; no event is lost in the base build.
  - Simultaneous push and pop when empty is not possible (pop is ignored when not ready).
  - Pointers are log2(FIFO_DEPTH)+1 bits; wrap naturally.
- Latency:
  - Raw edge at cycle 0, clean input, empty FIFO, no contention: user_event_ready_o rises at cycle DEBOUNCE_CYCLES+4.
  - Breakdown: 2 sync, DEBOUNCE_CYCLES debounce, 1 pending, 1 FIFO write.
- Ordering: FIFO output order equals push order; consumer sees events strictly in arbitration order.

Optional Feature:
USER_EVENT_DROP_ON_FULL_EN
- Defined:
  - When the FIFO is full with no pop and a pending flag is set, the arbiter winner's flag is cleared without a push.
  - overflow_o is set to 1 and stays set until reset.
  - Keeps input responsive; stale events are dropped.
- Undefined: block-on-full behaviour as above; overflow_o tied 0.

Test Plan:
Test params: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, FIFO_DEPTH=4.
1. key_rotate_i 0->1 at cycle 0, held 100 cycles -> user_event_ready_o=1 at cycle 8 with user_event_o=EV_ROTATE; exactly one event total.
2. key_left_i pulses of 3 cycles high, repeated with 3-cycle gaps -> no event ever; 4-cycle-stable press -> one EV_LEFT.
3. key_down_i held 60 cycles, rd_req held high -> EV_DOWN at press, repeats at press+20, +28, +36, +44, +52 (6 events); release stops repeats.
4. key_left_i and key_new_game_i pressed in the same cycle -> EV_NEW_GAME then EV_LEFT on consecutive cycles, popped in that order.
5. No pops, five distinct keys pressed -> FIFO holds 4 (NEW_GAME, ROTATE, DOWN, LEFT), RIGHT stays pending. One pop -> EV_RIGHT enters; 5 pops drain in priority order. With USER_EVENT_DROP_ON_FULL_EN: RIGHT dropped, overflow_o=1.
6. rst_i pulsed while FIFO holds 3 events and key_down_i held -> ready=0 immediately, FIFO empty; single EV_DOWN reappears 8 cycles after reset release.

Source files
------------

// File: rtl/user_event_gen_if.sv
// User-event handshake between the key event producer and the game FSM.
// The producer presents a show-ahead head code; the consumer pops it with a read request.
interface user_event_gen_if;
    logic [2:0] user_event;
    logic       user_event_ready;
    logic       user_event_rd_req;
    logic       overflow;

    modport master (
        output user_event,
        output user_event_ready,
        output overflow,
        input  user_event_rd_req
    );

    modport slave (
        input  user_event,
        input  user_event_ready,
        input  overflow,
        output user_event_rd_req
    );
endinterface

// File: rtl/user_event_gen.sv
// Five-key user-event producer: sync, debounce, press/auto-repeat, priority arbiter, show-ahead FIFO.
// Optional macro USER_EVENT_DROP_ON_FULL_EN drops the arbiter winner on a full FIFO and sets overflow.
module user_event_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned REPEAT_DELAY    = 12500000,
    parameter int unsigned REPEAT_PERIOD   = 5000000,
    parameter int unsigned FIFO_DEPTH      = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             key_left_i,
    input  logic             key_right_i,
    input  logic             key_down_i,
    input  logic             key_rotate_i,
    input  logic             key_new_game_i,
    user_event_gen_if.master ev_if
);

    localparam logic [2:0] EvLeft    = 3'd1;
    localparam logic [2:0] EvRight   = 3'd2;
    localparam logic [2:0] EvDown    = 3'd3;
    localparam logic [2:0] EvRotate  = 3'd4;
    localparam logic [2:0] EvNewGame = 3'd5;

    localparam int unsigned NumKeys  = 5;
    localparam int unsigned NumRep   = 3;
    localparam int unsigned KeyLeft  = 0;
    localparam int unsigned KeyRight = 1;
    localparam int unsigned KeyDown  = 2;
    localparam int unsigned KeyRot   = 3;
    localparam int unsigned KeyNew   = 4;

    localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RepW   = $clog2(RepMax + 1);
    localparam int unsigned AddrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned PtrW   = AddrW + 1;

    logic [NumKeys-1:0] key_raw;
    logic [NumKeys-1:0] sync1_q, sync2_q;
    logic [NumKeys-1:0] deb_q, deb_d, rise, fall;
    logic [DbW-1:0]     db_cnt_q [NumKeys];
    logic [DbW-1:0]     db_cnt_d [NumKeys];

    logic [RepW-1:0]    rep_cnt_q [NumRep];
    logic [RepW-1:0]    rep_cnt_d [NumRep];
    logic [RepW-1:0]    rep_lim   [NumRep];
    logic [NumRep-1:0]  rep_first_q, rep_first_d, rep_hit;

    logic [NumKeys-1:0] pend_q, pend_d, set_ev, win, clr;
    logic [2:0]         win_code;

    logic [2:0]         mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d, fill;
    logic               full, pop, push;
    logic [2:0]         head_d, event_q, event_d;
    logic               ready_q, ready_d;

    assign key_raw = {key_new_game_i, key_rotate_i, key_down_i, key_right_i, key_left_i};

    // A full count means the synced level differed for DEBOUNCE_CYCLES samples: accept it.
    always_comb begin
        for (int k = 0; k < NumKeys; k++) begin
            deb_d[k]    = deb_q[k];
            db_cnt_d[k] = db_cnt_q[k];
            if (db_cnt_q[k] == DbW'(DEBOUNCE_CYCLES)) begin
                deb_d[k]    = ~deb_q[k];
                db_cnt_d[k] = '0;
            end else if (sync2_q[k] != deb_q[k]) begin
                db_cnt_d[k] = db_cnt_q[k] + DbW'(1);
            end else begin
                db_cnt_d[k] = '0;
            end
        end
        rise = deb_d & ~deb_q;
        fall = ~deb_d & deb_q;
    end

    // Repeat counter holds cycles since the last press or repeat; no repeat on the release edge.
    always_comb begin
        for (int k = 0; k < NumRep; k++) begin
            rep_cnt_d[k]   = rep_cnt_q[k];
            rep_first_d[k] = rep_first_q[k];
            rep_hit[k]     = 1'b0;
            rep_lim[k]     = rep_first_q[k] ? RepW'(REPEAT_DELAY) : RepW'(REPEAT_PERIOD);
            if (rise[k]) begin
                rep_cnt_d[k]   = '0;
                rep_first_d[k] = 1'b1;
            end else if (!deb_q[k] || fall[k]) begin
                rep_cnt_d[k]   = '0;
            end else if ((rep_cnt_q[k] + RepW'(1)) == rep_lim[k]) begin
                rep_hit[k]     = 1'b1;
                rep_cnt_d[k]   = '0;
                rep_first_d[k] = 1'b0;
            end else begin
                rep_cnt_d[k]   = rep_cnt_q[k] + RepW'(1);
            end
        end
    end

    assign set_ev = rise | {2'b00, rep_hit};

    always_comb begin
        win      = '0;
        win_code = '0;
        if (pend_q[KeyNew]) begin
            win[KeyNew] = 1'b1;
            win_code    = EvNewGame;
        end else if (pend_q[KeyRot]) begin
            win[KeyRot] = 1'b1;
            win_code    = EvRotate;
        end else if (pend_q[KeyDown]) begin
            win[KeyDown] = 1'b1;
            win_code     = EvDown;
        end else if (pend_q[KeyLeft]) begin
            win[KeyLeft] = 1'b1;
            win_code     = EvLeft;
        end else if (pend_q[KeyRight]) begin
            win[KeyRight] = 1'b1;
            win_code      = EvRight;
        end
    end

    assign pop  = ev_if.user_event_rd_req & ready_q;
    assign fill = wptr_q - rptr_q;
    assign full = (fill == PtrW'(FIFO_DEPTH));

`ifdef USER_EVENT_DROP_ON_FULL_EN
    logic overflow_q, overflow_d;
`endif

    always_comb begin
        push = 1'b0;
        clr  = '0;
`ifdef USER_EVENT_DROP_ON_FULL_EN
        overflow_d = overflow_q;
`endif
        if (|win) begin
            if (!full || pop) begin
                push = 1'b1;
                clr  = win;
            end
`ifdef USER_EVENT_DROP_ON_FULL_EN
            else begin
                clr        = win;
                overflow_d = 1'b1;
            end
`endif
        end
        // A fresh press/repeat on the same edge as the winner's clear re-arms the flag.
        pend_d = (pend_q & ~clr) | set_ev;
        wptr_d = wptr_q + {{(PtrW-1){1'b0}}, push};
        rptr_d = rptr_q + {{(PtrW-1){1'b0}}, pop};
        head_d = mem_q[rptr_d[AddrW-1:0]];
        if (push && (wptr_q[AddrW-1:0] == rptr_d[AddrW-1:0])) begin
            head_d = win_code;
        end
        ready_d = (wptr_d != rptr_d);
        event_d = ready_d ? head_d : 3'd0;
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q[AddrW-1:0]] <= win_code;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            deb_q       <= '0;
            pend_q      <= '0;
            rep_first_q <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            ready_q     <= 1'b0;
            event_q     <= 3'd0;
            for (int k = 0; k < NumKeys; k++) db_cnt_q[k] <= '0;
            for (int k = 0; k < NumRep; k++) rep_cnt_q[k] <= '0;
`ifdef USER_EVENT_DROP_ON_FULL_EN
            overflow_q  <= 1'b0;
`endif
        end else begin
            sync1_q     <= key_raw;
            sync2_q     <= sync1_q;
            deb_q       <= deb_d;
            pend_q      <= pend_d;
            rep_first_q <= rep_first_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            ready_q     <= ready_d;
            event_q     <= event_d;
            for (int k = 0; k < NumKeys; k++) db_cnt_q[k] <= db_cnt_d[k];
            for (int k = 0; k < NumRep; k++) rep_cnt_q[k] <= rep_cnt_d[k];
`ifdef USER_EVENT_DROP_ON_FULL_EN
            overflow_q  <= overflow_d;
`endif
        end
    end

    assign ev_if.user_event       = event_q;
    assign ev_if.user_event_ready = ready_q;
`ifdef USER_EVENT_DROP_ON_FULL_EN
    assign ev_if.overflow         = overflow_q;
`else
    assign ev_if.overflow         = 1'b0;
`endif

endmodule

// File: tb/tb_user_event_gen.sv
// Bench for user_event_gen: directed scenarios plus random keys, scored against a timing model.
`timescale 1ns/1ps
module tb_user_event_gen;

    localparam int DB    = 4;
    localparam int RD    = 20;
    localparam int RP    = 8;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] keys = '0;   // 0 left, 1 right, 2 down, 3 rotate, 4 new game

    user_event_gen_if ev_if ();

    user_event_gen #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .key_left_i     (keys[0]),
        .key_right_i    (keys[1]),
        .key_down_i     (keys[2]),
        .key_rotate_i   (keys[3]),
        .key_new_game_i (keys[4]),
        .ev_if          (ev_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    int popped_log [$];
    logic [2:0] exp_q [$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [2:0] code_of(input int k);
        case (k)
            0:       return 3'd1;
            1:       return 3'd2;
            2:       return 3'd3;
            3:       return 3'd4;
            default: return 3'd5;
        endcase
    endfunction

    // Reference model: event times derived from the sampled raw history.
    int         t;
    logic [4:0] raw_log [$];
    logic [4:0] m_deb, m_pend;
    int         m_last_flip [5];
    int         m_press [5];
    int         m_cnt;
    logic       m_ovf;

    task automatic model_reset();
        t = 0;
        raw_log.delete();
        raw_log.push_back(5'b0);
        m_deb  = '0;
        m_pend = '0;
        m_cnt  = 0;
        m_ovf  = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 5; k++) begin
            m_last_flip[k] = 0;
            m_press[k]     = 0;
        end
    endtask

    function automatic logic syn(input int s, input int k);
        if (s - 2 >= 1) return raw_log[s-2][k];
        return 1'b0;
    endfunction

    task automatic model_step();
        int         prio [5];
        int         winner;
        bit         pop_now, full, flip, differ;
        logic [4:0] sets;
        int         e;
        prio = '{4, 3, 2, 0, 1};
        t++;
        raw_log.push_back(keys);
        pop_now = ev_if.user_event_rd_req && (m_cnt > 0);
        full    = (m_cnt == DEPTH);
        winner  = -1;
        for (int i = 0; i < 5; i++) begin
            if (winner < 0 && m_pend[prio[i]]) winner = prio[i];
        end
        if (winner >= 0 && (!full || pop_now)) begin
            exp_q.push_back(code_of(winner));
            m_cnt++;
            m_pend[winner] = 1'b0;
        end
`ifdef USER_EVENT_DROP_ON_FULL_EN
        else if (winner >= 0) begin
            m_pend[winner] = 1'b0;
            m_ovf          = 1'b1;
        end
`endif
        if (pop_now) m_cnt--;
        sets = '0;
        for (int k = 0; k < 5; k++) begin
            differ = (t - DB > m_last_flip[k]);
            for (int s = t - DB; s < t; s++) begin
                if (syn(s, k) == m_deb[k]) differ = 1'b0;
            end
            flip = differ;
            if (k < 3 && m_deb[k] && !flip) begin
                e = t - m_press[k];
                if (e == RD || (e > RD && ((e - RD) % RP) == 0)) sets[k] = 1'b1;
            end
            if (flip) begin
                m_deb[k]       = ~m_deb[k];
                m_last_flip[k] = t;
                if (m_deb[k]) begin
                    sets[k]    = 1'b1;
                    m_press[k] = t;
                end
            end
        end
        m_pend = m_pend | sets;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    // Monitor: compares DUT outputs with the model and pops the scoreboard on each read.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("ready", int'(ev_if.user_event_ready), int'(m_cnt > 0));
                check("overflow", int'(ev_if.overflow), int'(m_ovf));
                if (ev_if.user_event_ready && ev_if.user_event_rd_req) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pop_unexpected: got code %0d, expected no event",
                                 ev_if.user_event);
                    end else begin
                        check("event_code", int'(ev_if.user_event), int'(exp_q.pop_front()));
                    end
                    popped_log.push_back(int'(ev_if.user_event));
                    pops++;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ev_if.user_event_ready && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic settle();
        keys = '0;
        ev_if.user_event_rd_req = 1'b1;
        step(40);
    endtask

    int n, p0, hold [5];

    initial begin
        ev_if.user_event_rd_req = 1'b0;
        step(3);
        check("rst_ready", int'(ev_if.user_event_ready), 0);
        check("rst_event", int'(ev_if.user_event), 0);
        check("rst_overflow", int'(ev_if.overflow), 0);
        rst = 1'b0;
        step(5);

        // Rotate press latency and no repeat.
        p0 = pops;
        keys[3] = 1'b1;
        wait_ready(n);
        check("rotate_latency", n, DB + 4);
        check("rotate_code", int'(ev_if.user_event), 4);
        ev_if.user_event_rd_req = 1'b1;
        step(100 - n);
        keys[3] = 1'b0;
        step(20);
        check("rotate_single", pops - p0, 1);
        settle();

        // Short glitches ignored, a DB-cycle press accepted.
        p0 = pops;
        for (int i = 0; i < 5; i++) begin
            keys[0] = 1'b1;
            step(3);
            keys[0] = 1'b0;
            step(3);
        end
        step(20);
        check("glitch_ignored", pops - p0, 0);
        keys[0] = 1'b1;
        step(DB);
        keys[0] = 1'b0;
        step(20);
        check("stable_press", pops - p0, 1);
        check("stable_press_code", popped_log[popped_log.size()-1], 1);
        settle();

        // Down held: press plus five repeats.
        p0 = pops;
        keys[2] = 1'b1;
        step(60);
        keys[2] = 1'b0;
        step(40);
        check("down_repeats", pops - p0, 6);
        settle();

        // Simultaneous left and new-game.
        p0 = pops;
        keys[0] = 1'b1;
        keys[4] = 1'b1;
        step(10);
        keys = '0;
        step(20);
        check("simul_count", pops - p0, 2);
        check("simul_first", popped_log[p0], 5);
        check("simul_second", popped_log[p0+1], 1);
        settle();

        // Five keys into a four-entry FIFO with no reads.
        ev_if.user_event_rd_req = 1'b0;
        step(2);
        p0 = pops;
        keys = 5'b11111;
        step(10);
        keys = '0;
        step(20);
        check("full_ready", int'(ev_if.user_event_ready), 1);
        check("full_head", int'(ev_if.user_event), 5);
`ifdef USER_EVENT_DROP_ON_FULL_EN
        check("full_overflow", int'(ev_if.overflow), 1);
`else
        check("full_overflow", int'(ev_if.overflow), 0);
`endif
        ev_if.user_event_rd_req = 1'b1;
        step(1);
        ev_if.user_event_rd_req = 1'b0;
        step(3);
        ev_if.user_event_rd_req = 1'b1;
        step(12);
`ifdef USER_EVENT_DROP_ON_FULL_EN
        check("drain_count", pops - p0, 4);
`else
        check("drain_count", pops - p0, 5);
        check("drain_5", popped_log[p0+4], 2);
`endif
        check("drain_1", popped_log[p0], 5);
        check("drain_2", popped_log[p0+1], 4);
        check("drain_3", popped_log[p0+2], 3);
        check("drain_4", popped_log[p0+3], 1);
        settle();

        // Reset with events queued and down held.
        ev_if.user_event_rd_req = 1'b0;
        keys = 5'b01011;
        step(10);
        keys = '0;
        step(15);
        check("pre_reset_ready", int'(ev_if.user_event_ready), 1);
        keys[2] = 1'b1;
        step(2);
        rst = 1'b1;
        #1;
        check("async_rst_ready", int'(ev_if.user_event_ready), 0);
        check("async_rst_event", int'(ev_if.user_event), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        p0 = pops;
        wait_ready(n);
        check("post_reset_latency", n, DB + 4);
        check("post_reset_code", int'(ev_if.user_event), 3);
        keys[2] = 1'b0;
        ev_if.user_event_rd_req = 1'b1;
        step(30);
        check("post_reset_single", pops - p0, 1);
        settle();

        // Random keys and reads.
        for (int k = 0; k < 5; k++) hold[k] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 5; k++) begin
                if (hold[k] == 0) begin
                    keys[k] = ($urandom_range(0, 1) == 1);
                    hold[k] = ($urandom_range(0, 7) == 0) ? $urandom_range(25, 60)
                                                          : $urandom_range(1, 12);
                end else begin
                    hold[k]--;
                end
            end
            ev_if.user_event_rd_req = ($urandom_range(0, 3) != 0);
            step(1);
        end
        settle();
        step(60);
        check("final_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
